// File: rtl/dct_ctrl_pkg.sv
// Shared types for the MFCC DCT frame sequencer: FSM state encoding and err_o bit positions.
package dct_ctrl_pkg;

    typedef enum logic [2:0] {
        LOAD,
        START,
        RUN,
        DRAIN,
        FLUSH_WAIT
    } state_t;

    localparam int unsigned ERR_MISS = 0;
    localparam int unsigned ERR_TMO  = 1;
    localparam int unsigned ERR_W    = 2;

endpackage

// File: rtl/dct_frame_ctrl_ceps_buffer.sv
// Cepstral capture buffer: NUM_CEPS x CEPS_WIDTH register file plus a per-entry captured mask.
// Entries whose mask bit is clear read back as zero, so a stale frame never leaks downstream.
module ceps_buffer #(
    parameter int unsigned NUM_CEPS   = 12,
    parameter int unsigned CEPS_WIDTH = 16,
    parameter int unsigned NC_LOG2    = $clog2(NUM_CEPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_wr_en,
    input  logic [NC_LOG2-1:0]    i_wr_idx,
    input  logic [CEPS_WIDTH-1:0] i_wr_data,
    input  logic [NC_LOG2-1:0]    i_rd_idx,
    output logic [CEPS_WIDTH-1:0] o_rd_data,
    output logic                  o_dup,
    output logic                  o_all_set_next
);

    logic [CEPS_WIDTH-1:0] r_mem [NUM_CEPS];
    logic [NUM_CEPS-1:0]   r_mask;

    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_hit;
    logic [NUM_CEPS-1:0]   w_wr_onehot;

    assign w_wr_in_range = (32'(i_wr_idx) < NUM_CEPS);
    assign w_rd_in_range = (32'(i_rd_idx) < NUM_CEPS);
    assign w_hit         = i_wr_en && w_wr_in_range;
    assign w_wr_onehot   = w_hit ? (NUM_CEPS'(1) << i_wr_idx) : '0;

    assign o_dup          = w_hit && r_mask[i_wr_idx];
    assign o_all_set_next = &(r_mask | w_wr_onehot);
    assign o_rd_data      = (w_rd_in_range && r_mask[i_rd_idx]) ? r_mem[i_rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (w_hit) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
        end else if (i_clr) begin
            r_mask <= '0;
        end else begin
            r_mask <= r_mask | w_wr_onehot;
        end
    end

endmodule

// File: rtl/dct_frame_ctrl.sv
// MFCC DCT frame sequencer: loads mel energies, starts the DCT, captures and drains coefficients.
// Optional RUN/FLUSH_WAIT watchdog is built when DCT_CTRL_TIMEOUT_EN is defined.
module dct_frame_ctrl
    import dct_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CEPS       = 12,
    parameter int unsigned NUM_FILTERS    = 40,
    parameter int unsigned INPUT_WIDTH    = 8,
    parameter int unsigned CEPS_WIDTH     = 16,
    parameter int unsigned NF_LOG2        = $clog2(NUM_FILTERS),
    parameter int unsigned NC_LOG2        = $clog2(NUM_CEPS),
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   mel_valid_i,
    input  logic [INPUT_WIDTH-1:0] mel_data_i,
    output logic                   mel_ready_o,
    output logic                   dct_in_valid_o,
    output logic [NF_LOG2-1:0]     dct_frame_ptr_o,
    output logic [INPUT_WIDTH-1:0] dct_power_o,
    output logic                   dct_start_o,
    input  logic                   dct_valid_i,
    input  logic [CEPS_WIDTH-1:0]  dct_ceps_i,
    input  logic [NC_LOG2-1:0]     dct_ceps_ptr_i,
    input  logic                   dct_done_i,
    output logic                   ceps_valid_o,
    output logic [CEPS_WIDTH-1:0]  ceps_data_o,
    output logic [NC_LOG2-1:0]     ceps_idx_o,
    output logic                   ceps_last_o,
    input  logic                   ceps_ready_i,
    output logic                   busy_o,
    output logic [15:0]            frame_cnt_o,
    output logic [ERR_W-1:0]       err_o
);

    state_t                 r_state;
    logic [NF_LOG2-1:0]     r_load_cnt;
    logic                   r_mel_ready;
    logic                   r_dct_in_valid;
    logic [NF_LOG2-1:0]     r_dct_ptr;
    logic [INPUT_WIDTH-1:0] r_dct_power;
    logic                   r_dct_start;
    logic                   r_ceps_valid;
    logic [NC_LOG2-1:0]     r_idx;
    logic [15:0]            r_frame_cnt;
    logic [ERR_W-1:0]       r_err;

    logic                   w_accept;
    logic                   w_last_beat;
    logic                   w_idx_last;
    logic                   w_drain_done;
    logic                   w_wr_en;
    logic                   w_clr;
    logic                   w_dup;
    logic                   w_all_set_next;
    logic                   w_tmo_hit;
    logic [CEPS_WIDTH-1:0]  w_rd_data;

    assign w_accept     = mel_valid_i && r_mel_ready;
    assign w_last_beat  = (r_load_cnt == NF_LOG2'(NUM_FILTERS - 1));
    assign w_idx_last   = (r_idx == NC_LOG2'(NUM_CEPS - 1));
    assign w_drain_done = (r_state == DRAIN) && ceps_ready_i && w_idx_last;
    assign w_wr_en      = (r_state == RUN) && dct_valid_i && !flush_i && !w_tmo_hit;

    // Mask is wiped on every frame exit path and again on entry to RUN.
    assign w_clr = (flush_i && (r_state == RUN || r_state == DRAIN)) || w_tmo_hit ||
                   (!flush_i && w_drain_done) || (r_state == START);

`ifdef DCT_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_in_wait;

    assign w_in_wait = (r_state == RUN) || (r_state == FLUSH_WAIT);
    assign w_tmo_hit = w_in_wait && !dct_done_i && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // A flush from RUN restarts the budget so FLUSH_WAIT gets a full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (!w_in_wait || (r_state == RUN && flush_i)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    ceps_buffer #(
        .NUM_CEPS   (NUM_CEPS),
        .CEPS_WIDTH (CEPS_WIDTH),
        .NC_LOG2    (NC_LOG2)
    ) u_ceps_buffer (
        .clk            (clk),
        .rst            (rst),
        .i_clr          (w_clr),
        .i_wr_en        (w_wr_en),
        .i_wr_idx       (dct_ceps_ptr_i),
        .i_wr_data      (dct_ceps_i),
        .i_rd_idx       (r_idx),
        .o_rd_data      (w_rd_data),
        .o_dup          (w_dup),
        .o_all_set_next (w_all_set_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= LOAD;
            r_load_cnt     <= '0;
            r_mel_ready    <= 1'b1;
            r_dct_in_valid <= 1'b0;
            r_dct_ptr      <= '0;
            r_dct_power    <= '0;
            r_dct_start    <= 1'b0;
            r_ceps_valid   <= 1'b0;
            r_idx          <= '0;
            r_frame_cnt    <= '0;
            r_err          <= '0;
        end else begin
            r_dct_in_valid <= 1'b0;
            r_dct_start    <= 1'b0;
            if (flush_i) begin
                r_err <= '0;
                unique case (r_state)
                    LOAD, START: begin
                        r_state     <= LOAD;
                        r_load_cnt  <= '0;
                        r_mel_ready <= 1'b1;
                    end
                    RUN: begin
                        r_state     <= FLUSH_WAIT;
                        r_mel_ready <= 1'b0;
                    end
                    FLUSH_WAIT: begin
                        if (dct_done_i || w_tmo_hit) begin
                            r_state     <= LOAD;
                            r_mel_ready <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        r_state      <= LOAD;
                        r_ceps_valid <= 1'b0;
                        r_idx        <= '0;
                        r_mel_ready  <= 1'b1;
                    end
                    default: r_state <= LOAD;
                endcase
            end else begin
                unique case (r_state)
                    LOAD: begin
                        if (w_accept) begin
                            r_dct_in_valid <= 1'b1;
                            r_dct_ptr      <= r_load_cnt;
                            r_dct_power    <= mel_data_i;
                            if (w_last_beat) begin
                                r_load_cnt  <= '0;
                                r_mel_ready <= 1'b0;
                                r_state     <= START;
                            end else begin
                                r_load_cnt <= r_load_cnt + 1'b1;
                            end
                        end
                    end
                    START: begin
                        r_dct_start <= 1'b1;
                        r_state     <= RUN;
                    end
                    RUN: begin
                        if (w_tmo_hit) begin
                            r_err[ERR_TMO] <= 1'b1;
                            r_state        <= LOAD;
                            r_mel_ready    <= 1'b1;
                        end else begin
                            if (w_dup) begin
                                r_err[ERR_MISS] <= 1'b1;
                            end
                            if (dct_done_i) begin
                                if (!w_all_set_next) begin
                                    r_err[ERR_MISS] <= 1'b1;
                                end
                                r_state      <= DRAIN;
                                r_ceps_valid <= 1'b1;
                                r_idx        <= '0;
                            end
                        end
                    end
                    DRAIN: begin
                        if (ceps_ready_i) begin
                            if (w_idx_last) begin
                                r_ceps_valid <= 1'b0;
                                r_idx        <= '0;
                                r_frame_cnt  <= r_frame_cnt + 1'b1;
                                r_state      <= LOAD;
                                r_mel_ready  <= 1'b1;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    FLUSH_WAIT: begin
                        if (dct_done_i) begin
                            r_state     <= LOAD;
                            r_mel_ready <= 1'b1;
                        end else if (w_tmo_hit) begin
                            r_err[ERR_TMO] <= 1'b1;
                            r_state        <= LOAD;
                            r_mel_ready    <= 1'b1;
                        end
                    end
                    default: r_state <= LOAD;
                endcase
            end
        end
    end

    assign mel_ready_o     = r_mel_ready;
    assign dct_in_valid_o  = r_dct_in_valid;
    assign dct_frame_ptr_o = r_dct_ptr;
    assign dct_power_o     = r_dct_power;
    assign dct_start_o     = r_dct_start;
    assign ceps_valid_o    = r_ceps_valid;
    assign ceps_data_o     = r_ceps_valid ? w_rd_data : '0;
    assign ceps_idx_o      = r_idx;
    assign ceps_last_o     = r_ceps_valid && w_idx_last;
    assign busy_o          = (r_state != LOAD) || (r_load_cnt != '0);
    assign frame_cnt_o     = r_frame_cnt;
    assign err_o           = r_err;

endmodule

// File: tb/tb_dct_frame_ctrl.sv
// Directed self-checking bench for dct_frame_ctrl: normal frames, back-pressure, missing
// coefficient, flushes, stray DCT events, async reset and (with DCT_CTRL_TIMEOUT_EN) the watchdog.
module tb_dct_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        mel_valid_i = 1'b0;
    logic [7:0]  mel_data_i = '0;
    logic        mel_ready_o;
    logic        dct_in_valid_o;
    logic [5:0]  dct_frame_ptr_o;
    logic [7:0]  dct_power_o;
    logic        dct_start_o;
    logic        dct_valid_i = 1'b0;
    logic [15:0] dct_ceps_i = '0;
    logic [3:0]  dct_ceps_ptr_i = '0;
    logic        dct_done_i = 1'b0;
    logic        ceps_valid_o;
    logic [15:0] ceps_data_o;
    logic [3:0]  ceps_idx_o;
    logic        ceps_last_o;
    logic        ceps_ready_i = 1'b0;
    logic        busy_o;
    logic [15:0] frame_cnt_o;
    logic [1:0]  err_o;

    dct_frame_ctrl u_dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .mel_valid_i     (mel_valid_i),
        .mel_data_i      (mel_data_i),
        .mel_ready_o     (mel_ready_o),
        .dct_in_valid_o  (dct_in_valid_o),
        .dct_frame_ptr_o (dct_frame_ptr_o),
        .dct_power_o     (dct_power_o),
        .dct_start_o     (dct_start_o),
        .dct_valid_i     (dct_valid_i),
        .dct_ceps_i      (dct_ceps_i),
        .dct_ceps_ptr_i  (dct_ceps_ptr_i),
        .dct_done_i      (dct_done_i),
        .ceps_valid_o    (ceps_valid_o),
        .ceps_data_o     (ceps_data_o),
        .ceps_idx_o      (ceps_idx_o),
        .ceps_last_o     (ceps_last_o),
        .ceps_ready_i    (ceps_ready_i),
        .busy_o          (busy_o),
        .frame_cnt_o     (frame_cnt_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_frames = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] pat(input int n);
        return 8'(n * 5 + 3);
    endfunction

    // Write-side monitor: tracks pointer/data sequence and start-pulse placement.
    int mon_ptr = 0;
    int mon_in_cnt = 0;
    int mon_start_cnt = 0;
    int mon_bad = 0;
    bit mon_prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mon_ptr       <= 0;
            mon_prev_last <= 1'b0;
        end else begin
            if (dct_in_valid_o) begin
                if (int'(dct_frame_ptr_o) != mon_ptr || dct_power_o != pat(mon_ptr))
                    mon_bad <= mon_bad + 1;
                mon_in_cnt <= mon_in_cnt + 1;
            end
            if (flush_i) mon_ptr <= 0;
            else if (dct_in_valid_o) mon_ptr <= (mon_ptr == 39) ? 0 : mon_ptr + 1;
            if (dct_start_o) begin
                mon_start_cnt <= mon_start_cnt + 1;
                if (!mon_prev_last) mon_bad <= mon_bad + 1;
            end
            mon_prev_last <= dct_in_valid_o && (dct_frame_ptr_o == 6'd39);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beats(input int cnt, input bit keep_high);
        int n = 0;
        int g = 0;
        bit rdy;
        while (n < cnt && g < 400) begin
            mel_valid_i = 1'b1;
            mel_data_i  = pat(n);
            rdy = mel_ready_o;
            tick();
            g++;
            if (rdy) n++;
        end
        if (!keep_high) mel_valid_i = 1'b0;
        chk("send_beats", n, cnt);
    endtask

    task automatic wait_start();
        int g = 0;
        while (!dct_start_o && g < 50) begin
            tick();
            g++;
        end
        chk("start_seen", dct_start_o, 1);
        mel_valid_i = 1'b0;
        chk("run_mel_ready_low", mel_ready_o, 0);
    endtask

    task automatic drive_ceps(input int n, input int skip);
        for (int k = 0; k < n; k++) begin
            dct_valid_i    = (k != skip);
            dct_ceps_ptr_i = 4'(k);
            dct_ceps_i     = 16'(100 + k);
            tick();
        end
        dct_valid_i = 1'b0;
    endtask

    task automatic pulse_done();
        dct_done_i = 1'b1;
        tick();
        dct_done_i = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic recv(input bit toggle, input int skip);
        int k = 0;
        int g = 0;
        bit rdy = 1'b0;
        bit stalled = 1'b0;
        logic [15:0] held_data;
        logic [3:0]  held_idx;
        while (k < 12 && g < 300) begin
            rdy = toggle ? !rdy : 1'b1;
            ceps_ready_i = rdy;
            if (ceps_valid_o) begin
                if (stalled) begin
                    chk("stall_data_stable", ceps_data_o, held_data);
                    chk("stall_idx_stable", ceps_idx_o, held_idx);
                end
                if (rdy) begin
                    chk("ceps_idx", ceps_idx_o, k);
                    chk("ceps_data", ceps_data_o, (k == skip) ? 0 : 100 + k);
                    chk("ceps_last", ceps_last_o, k == 11);
                    k++;
                    stalled = 1'b0;
                end else begin
                    held_data = ceps_data_o;
                    held_idx  = ceps_idx_o;
                    stalled   = 1'b1;
                end
            end
            tick();
            g++;
        end
        ceps_ready_i = 1'b0;
        chk("recv_count", k, 12);
    endtask

    task automatic do_frame(input bit toggle, input int skip);
        int in0 = mon_in_cnt;
        int st0 = mon_start_cnt;
        send_beats(40, 1'b1);
        wait_start();
        drive_ceps(12, skip);
        pulse_done();
        chk("err_after_done", err_o, (skip >= 0) ? 2'b01 : 2'b00);
        chk("drain_valid", ceps_valid_o, 1);
        recv(toggle, skip);
        exp_frames++;
        chk("frame_cnt", frame_cnt_o, exp_frames);
        chk("post_mel_ready", mel_ready_o, 1);
        chk("post_ceps_valid", ceps_valid_o, 0);
        chk("post_busy", busy_o, 0);
        chk("in_valid_count", mon_in_cnt - in0, 40);
        chk("start_pulses", mon_start_cnt - st0, 1);
        chk("write_seq_errors", mon_bad, 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mel_ready", mel_ready_o, 1);
        chk("rst_in_valid", dct_in_valid_o, 0);
        chk("rst_start", dct_start_o, 0);
        chk("rst_ceps_valid", ceps_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_frame_cnt", frame_cnt_o, 0);
        chk("rst_err", err_o, 0);

        do_frame(1'b0, -1);
        do_frame(1'b1, -1);
        do_frame(1'b0, 5);
        chk("err_sticky", err_o, 2'b01);
        pulse_flush();
        chk("flush_clears_err", err_o, 2'b00);
        chk("flush_frame_cnt", frame_cnt_o, exp_frames);

        // flush while the DCT is running
        send_beats(40, 1'b1);
        wait_start();
        drive_ceps(3, -1);
        pulse_flush();
        chk("fw_mel_ready", mel_ready_o, 0);
        chk("fw_busy", busy_o, 1);
        repeat (5) tick();
        chk("fw_mel_ready_hold", mel_ready_o, 0);
        chk("fw_ceps_valid", ceps_valid_o, 0);
        pulse_done();
        chk("fw_exit_mel_ready", mel_ready_o, 1);
        chk("fw_exit_ceps_valid", ceps_valid_o, 0);
        chk("fw_frame_cnt", frame_cnt_o, exp_frames);
        chk("fw_busy_clear", busy_o, 0);

        // stray DCT events in LOAD are ignored
        dct_valid_i = 1'b1;
        dct_ceps_ptr_i = 4'd3;
        dct_ceps_i = 16'hdead;
        dct_done_i = 1'b1;
        tick();
        dct_valid_i = 1'b0;
        dct_done_i = 1'b0;
        chk("stray_err", err_o, 0);
        chk("stray_ceps_valid", ceps_valid_o, 0);
        chk("stray_busy", busy_o, 0);
        chk("stray_mel_ready", mel_ready_o, 1);

        // partial load then flush; next frame must restart at ptr 0
        send_beats(10, 1'b0);
        chk("partial_busy", busy_o, 1);
        pulse_flush();
        chk("partial_flush_busy", busy_o, 0);
        chk("partial_flush_ready", mel_ready_o, 1);
        tick();
        do_frame(1'b0, -1);

`ifdef DCT_CTRL_TIMEOUT_EN
        send_beats(40, 1'b1);
        wait_start();
        repeat (1023) tick();
        chk("tmo_not_yet", err_o, 2'b00);
        chk("tmo_still_run", mel_ready_o, 0);
        tick();
        chk("tmo_err", err_o, 2'b10);
        chk("tmo_mel_ready", mel_ready_o, 1);
        chk("tmo_busy", busy_o, 0);
        chk("tmo_frame_cnt", frame_cnt_o, exp_frames);
`endif

        // asynchronous reset mid-load
        send_beats(20, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("arst_mel_ready", mel_ready_o, 1);
        chk("arst_busy", busy_o, 0);
        chk("arst_frame_cnt", frame_cnt_o, 0);
        chk("arst_in_valid", dct_in_valid_o, 0);
        chk("arst_err", err_o, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
